mc_core: RTL

//  Parametrised multi-cycle successor to the single-cycle 9-bit-ISA datapath.

---
 rtl/core_pkg.sv | 34 +++
 rtl/core_regfile.sv | 44 ++++
 rtl/mc_core.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and instruction-field positions for the multi-cycle 9-bit-ISA core.
package core_pkg;

   typedef enum logic [2:0] {
      OP_MOV = 3'b000,
      OP_ADD = 3'b001,
      OP_XOR = 3'b010,
      OP_AND = 3'b011,
      OP_LDI = 3'b100,
      OP_LD  = 3'b101,
      OP_ST  = 3'b110,
      OP_BEQ = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_HALT  = 3'd4
   } state_e;

   localparam int OP_HI  = 8;
   localparam int OP_LO  = 6;
   localparam int B_HI   = 5;
   localparam int B_LO   = 3;
   localparam int A_HI   = 2;
   localparam int A_LO   = 0;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;

   localparam logic [2:0] R_OUT = 3'd7;

endpackage

// File: rtl/core_regfile.sv
// Eight-entry register file: two async read ports, one write port, plus a
// fixed tap on the OUT register that branch offsets are taken from.
module core_regfile
   import core_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [2:0]   ra_addr,
   input  logic [2:0]   rb_addr,
   output logic [W-1:0] ra_data,
   output logic [W-1:0] rb_data,
   output logic [W-1:0] r_out,
   input  logic         we,
   input  logic [2:0]   waddr,
   input  logic [W-1:0] wdata
);

   logic [W-1:0] regs_q [8];
   logic [W-1:0] regs_d [8];

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ra_data = regs_q[ra_addr];
   assign rb_data = regs_q[rb_addr];
   assign r_out   = regs_q[R_OUT];

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 9-bit-ISA datapath: run/halt FSM, PC, ALU, branch logic and
// per-run cycle/instruction counters around an external ROM and data memory.
module mc_core
   import core_pkg::*;
#(
   parameter int D       = 12,
   parameter int W       = 8,
   parameter int HALT_PC = 512,
   parameter int CW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [D-1:0]  imem_addr,
   input  logic [8:0]    imem_data,
   output logic [W-1:0]  dmem_addr,
   output logic [W-1:0]  dmem_wdata,
   output logic          dmem_we,
   input  logic [W-1:0]  dmem_rdata,
   output logic          zero_flag,
   output logic [CW-1:0] cycle_cnt,
   output logic [CW-1:0] instr_cnt
);

   localparam logic [D-1:0] HALT_ADDR = D'(HALT_PC);

   state_e        state_q, state_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [8:0]    ir_q, ir_d;
   logic          zero_q, zero_d;
   logic [CW-1:0] cycle_q, cycle_d;
   logic [CW-1:0] instr_q, instr_d;

   op_e           op;
   logic [2:0]    a_idx, b_idx;
   logic [W-1:0]  ra_data, rb_data, r_out, imm;
   logic [D-1:0]  pc_inc, br_off;
   logic          rf_we;
   logic [2:0]    rf_waddr;
   logic [W-1:0]  rf_wdata;

   assign op     = op_e'(ir_q[OP_HI:OP_LO]);
   assign b_idx  = ir_q[B_HI:B_LO];
   assign a_idx  = ir_q[A_HI:A_LO];
   assign imm    = W'(ir_q[IMM_HI:IMM_LO]);
   assign pc_inc = pc_q + D'(1);
   // r7 is a signed W-bit offset; the cast sign-extends (or truncates) to D bits
   assign br_off = D'($signed(r_out));

   core_regfile #(.W(W)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .ra_addr (a_idx),
      .rb_addr (b_idx),
      .ra_data (ra_data),
      .rb_data (rb_data),
      .r_out   (r_out),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata)
   );

   assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
   assign done      = (state_q == S_HALT);
   assign imem_addr = pc_q;
   assign zero_flag = zero_q;
   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      zero_d     = zero_q;
      cycle_d    = cycle_q;
      instr_d    = instr_q;
      rf_we      = 1'b0;
      rf_waddr   = b_idx;
      rf_wdata   = ra_data;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_we    = 1'b0;

      if (busy && (cycle_q != {CW{1'b1}})) begin
         cycle_d = cycle_q + CW'(1);
      end

      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
               cycle_d = '0;
               instr_d = '0;
            end
         end

         S_FETCH: begin
            ir_d    = imem_data;
            state_d = S_EXEC;
         end

         S_EXEC: begin
            if (op == OP_LD) begin
               dmem_addr = ra_data;
               state_d   = S_MEM;
            end else begin
               pc_d    = pc_inc;
               instr_d = instr_q + CW'(1);
               unique case (op)
                  OP_MOV: begin
                     rf_we    = 1'b1;
                     rf_waddr = b_idx;
                     rf_wdata = ra_data;
                  end
                  OP_ADD: begin
                     rf_we    = 1'b1;
                     rf_waddr = R_OUT;
                     rf_wdata = ra_data + rb_data;
                     zero_d   = (rf_wdata == '0);
                  end
                  OP_XOR: begin
                     rf_we    = 1'b1;
                     rf_waddr = R_OUT;
                     rf_wdata = ra_data ^ rb_data;
                     zero_d   = (rf_wdata == '0);
                  end
                  OP_AND: begin
                     rf_we    = 1'b1;
                     rf_waddr = R_OUT;
                     rf_wdata = ra_data & rb_data;
                     zero_d   = (rf_wdata == '0);
                  end
                  OP_LDI: begin
                     rf_we    = 1'b1;
                     rf_waddr = R_OUT;
                     rf_wdata = imm;
                  end
                  OP_ST: begin
                     dmem_addr  = ra_data;
                     dmem_wdata = rb_data;
                     dmem_we    = 1'b1;
                  end
                  OP_BEQ: begin
                     if (ra_data == rb_data) begin
                        pc_d = pc_q + br_off;
                     end
                  end
                  default: begin
                  end
               endcase
               state_d = (pc_d == HALT_ADDR) ? S_HALT : S_FETCH;
            end
         end

         S_MEM: begin
            rf_we    = 1'b1;
            rf_waddr = b_idx;
            rf_wdata = dmem_rdata;
            pc_d     = pc_inc;
            instr_d  = instr_q + CW'(1);
            state_d  = (pc_d == HALT_ADDR) ? S_HALT : S_FETCH;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         zero_q  <= 1'b0;
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         zero_q  <= zero_d;
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

endmodule
